// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, next-PC selection, stall/flush handling and the IF/ID register.
// Optional feature macro: IF_PERF_CNT_EN builds the saturating stall/flush event counters.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  output logic [31:0] pc_o,
  output logic [31:0] ifid_pc4_o,
  output logic [31:0] ifid_instr_o,
  output logic        ifid_valid_o,
  output logic        flush_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o,
  output logic [1:0]  state_o
);

  localparam logic [31:0] END_ADDR = 32'(IMEM_DEPTH * 4);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        flush_q, flush_d;
  logic        stall_ev, flush_ev;

  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        seq_in_range;
  logic        tgt_in_range;

  assign pc_plus4     = pc_q + 32'd4;
  assign target       = {redirect_pc_i[31:2], 2'b00};
  assign seq_in_range = (pc_plus4 < END_ADDR);
  assign tgt_in_range = (target < END_ADDR);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    flush_d      = 1'b0;
    stall_ev     = 1'b0;
    flush_ev     = 1'b0;

    case (state_q)
      IDLE: begin
        ifid_pc4_d   = 32'h0;
        ifid_instr_d = 32'h0;
        ifid_valid_d = 1'b0;
        if (start_i) begin
          ifid_pc4_d   = pc_plus4;
          ifid_instr_d = imem_instr_i;
          ifid_valid_d = 1'b1;
          if (seq_in_range) begin
            pc_d    = pc_plus4;
            state_d = RUN;
          end else begin
            state_d = HALT;
          end
        end
      end

      RUN: begin
        if (!start_i) begin
          state_d      = IDLE;
          ifid_pc4_d   = 32'h0;
          ifid_instr_d = 32'h0;
          ifid_valid_d = 1'b0;
        end else if (stall_i) begin
          // Redirect under a stall is dropped; ID re-presents the branch next cycle.
          stall_ev = 1'b1;
        end else if (redirect_i) begin
          pc_d         = target;
          ifid_pc4_d   = 32'h0;
          ifid_instr_d = 32'h0;
          ifid_valid_d = 1'b0;
          flush_d      = 1'b1;
          flush_ev     = 1'b1;
          state_d      = tgt_in_range ? RUN : HALT;
        end else begin
          // The last in-range word is still fetched; only the PC stops advancing.
          ifid_pc4_d   = pc_plus4;
          ifid_instr_d = imem_instr_i;
          ifid_valid_d = 1'b1;
          if (seq_in_range) pc_d = pc_plus4;
          else state_d = HALT;
        end
      end

      HALT: begin
        if (stall_i) begin
          stall_ev = 1'b1;
        end else begin
          ifid_pc4_d   = 32'h0;
          ifid_instr_d = 32'h0;
          ifid_valid_d = 1'b0;
          if (redirect_i && tgt_in_range) begin
            pc_d     = target;
            flush_d  = 1'b1;
            flush_ev = 1'b1;
            state_d  = RUN;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      ifid_pc4_q   <= 32'h0;
      ifid_instr_q <= 32'h0;
      ifid_valid_q <= 1'b0;
      flush_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      flush_q      <= flush_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  // Event counters saturate instead of wrapping.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cnt_q <= 32'h0;
      flush_cnt_q <= 32'h0;
    end else begin
      if (stall_ev && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_ev && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  logic unused_ev;
  assign unused_ev   = stall_ev ^ flush_ev;
  assign stall_cnt_o = 32'h0;
  assign flush_cnt_o = 32'h0;
`endif

  logic unused_tgt_bits;
  assign unused_tgt_bits = ^redirect_pc_i[1:0];

  assign imem_addr_o  = pc_q;
  assign pc_o         = pc_q;
  assign ifid_pc4_o   = ifid_pc4_q;
  assign ifid_instr_o = ifid_instr_q;
  assign ifid_valid_o = ifid_valid_q;
  assign flush_o      = flush_q;
  assign state_o      = state_q;

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage pipelined CPU, sitting directly upstream of the IF/ID boundary and feeding the decode stage. It owns the program counter, next-PC selection (sequential, branch/jump redirect), hazard-driven stall and flush handling, and the IF/ID pipeline register. It also keeps per-run stall and flush event counters, so the top-level bench reads them instead of reconstructing them from decode signals.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_DEPTH, 256, instruction memory size in 32-bit words. The end-of-program address is IMEM_DEPTH*4.

Ports:
- clk_i  in  1  single clock; all state updates on posedge.
- rst_i  in  1  reset, synchronous, active-low (0 = reset on the next posedge).
- start_i  in  1  run enable. While 0, the PC is held.
- stall_i  in  1  load-use bubble from the hazard unit. Holds the PC and IF/ID.
- redirect_i  in  1  branch taken or jump, resolved in ID.
- redirect_pc_i  in  32  redirect target.
- imem_addr_o  out  32  instruction memory byte address (combinational, equals pc_o).
- imem_instr_i  in  32  instruction word from memory (combinational read, same cycle).
- pc_o  out  32  current PC.
- ifid_pc4_o  out  32  registered PC+4 of the instruction in IF/ID.
- ifid_instr_o  out  32  registered instruction (32'h0 = NOP).
- ifid_valid_o  out  1  IF/ID holds a real instruction.
- flush_o  out  1  registered: IF/ID was squashed at the last edge.
- stall_cnt_o  out  32  effective stall cycles.
- flush_cnt_o  out  32  effective flushes.

## Operation
- FSM states: IDLE, RUN, HALT.
- Reset (rst_i=0 at posedge) takes priority over everything. It sets:
  - pc_o=RESET_PC, ifid_instr_o=0, ifid_pc4_o=0, ifid_valid_o=0, flush_o=0
  - both counters = 0
  - state = IDLE
- IDLE:
  - PC is held and IF/ID loads NOP with valid=0.
  - Go to RUN at the posedge where start_i=1. That same edge performs the first fetch.
- RUN, per-edge priority is stall > redirect > sequential:
  - stall_i=1: PC and IF/ID hold. A redirect_i asserted in the same cycle is ignored (the branch in ID is re-presented next cycle). stall_cnt increments.
  - redirect_i=1, stall_i=0: PC <= {redirect_pc_i[31:2],2'b00}. IF/ID <= NOP with valid=0. flush_o <= 1. flush_cnt increments.
  - Otherwise: PC <= PC+4. IF/ID <= {PC+4, imem_instr_i, valid=1}. flush_o <= 0.
- start_i=0 while in RUN: go to IDLE. PC holds, IF/ID loads NOP.
- HALT:
  - Entered when the next PC would be >= IMEM_DEPTH*4.
  - While in HALT, PC holds and IF/ID loads NOP with valid=0.
  - A non-stalled redirect to an in-range target returns to RUN with normal flush semantics. A redirect to an out-of-range target stays in HALT.
- Arithmetic:
  - PC+4 is modulo 2^32.
  - Redirect target bits [1:0] are forced to 0.
  - Counters saturate at 32'hFFFF_FFFF and never wrap.
- Counters advance only in RUN/HALT (not in IDLE, not under reset).

## Timing
- Fetch-to-IF/ID latency: 1 cycle. The instruction at pc_o appears on ifid_instr_o after the next posedge.
- Redirect penalty: exactly 1 NOP bubble. The target instruction reaches IF/ID 2 edges after redirect_i is sampled.
- Stall: outputs are frozen for exactly the number of cycles stall_i is high. There is no extra bubble on release.
- flush_o is high for exactly one cycle per effective redirect.
- Reset mid-run: the next edge returns all outputs to their reset values. An in-flight redirect is discarded.

## Configuration
- IF_PERF_CNT_EN defined: the stall and flush counters are built as described.
- IF_PERF_CNT_EN undefined: the counters are not instantiated, stall_cnt_o and flush_cnt_o are tied to 32'h0, and all other behaviour is identical.

## Test plan
- Reset, then start_i=1, with memory words 1..5 at 0x0..0x10, no hazards:
  - pc_o steps 0,4,8,…
  - ifid_instr_o follows one cycle later with valid=1.
  - both counters remain 0.
- Stall for 2 cycles at PC=0x8:
  - pc_o holds at 0x8 for 2 edges and IF/ID holds the word from 0x4.
  - stall_cnt_o=2.
  - sequential fetch resumes at 0xC with no extra bubble.
- Redirect at PC=0xC to 0x41:
  - next pc_o=0x40 and IF/ID=NOP with valid=0.
  - flush_o is high for 1 cycle and flush_cnt_o=1.
  - the word from 0x40 reaches IF/ID on the following edge.
- stall_i and redirect_i high together:
  - PC holds and no flush occurs (flush_cnt unchanged, stall_cnt +1).
  - redirect honoured on the next cycle once stall_i drops.
- Run off the end with IMEM_DEPTH=4:
  - pc_o stops at 0xC, state enters HALT, IF/ID emits NOPs.
  - a redirect to 0x0 resumes fetch.
- rst_i=0 mid-run, then compile without IF_PERF_CNT_EN:
  - all outputs return to reset values on the next edge (pc_o=RESET_PC).
  - in the no-macro build the counter outputs read 0 throughout.
